// File: rtl/caravel_user_counter_pkg.sv
// Shared constants and address decode for the Caravel user-area counter.
// Optional prescaler is controlled by the HONZALES_PRESCALER_EN macro.
package caravel_user_counter_pkg;

    localparam logic [31:0] CNT_ADDR      = 32'h3000_0000;
    localparam logic [31:0] PRESCALE_ADDR = 32'h3000_0004;

    localparam int EN_PIN   = 32;
    localparam int CNT_LSB  = 0;
    localparam int WRAP_PIN = 8;

    localparam int DEF_PRESCALE = 16;

    localparam logic [37:0] OEB_VAL = 38'h3F_FFFF_FE00;

    typedef enum logic [1:0] {
        SEL_CNT,
        SEL_PRE,
        SEL_NONE
    } sel_e;

    function automatic sel_e decode(input logic [31:0] adr);
        if (adr == CNT_ADDR)
            return SEL_CNT;
        if (adr == PRESCALE_ADDR)
            return SEL_PRE;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/caravel_user_counter_if.sv
// Wishbone slave bundle between the management SoC and the user counter.
// Signal names follow the Caravel wrapper pinout.
interface caravel_user_counter_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/caravel_user_counter_tick_gen.sv
// Prescaler: emits a one-cycle tick every `period` cycles; clr restarts it.
// Only instantiated when HONZALES_PRESCALER_EN is defined.
module tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [15:0] period,
    output logic        tick
);

    logic [15:0] pcnt;

    // >= keeps the tick alive if period shrinks below the running count
    assign tick = !clr && (pcnt >= period - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || clr)
            pcnt <= '0;
        else if (tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + 16'd1;
    end

endmodule

// File: rtl/caravel_user_counter.sv
// Caravel user counter: enable-gated counter on pads with wrap strobe and a
// Wishbone slave; prescaler present only with HONZALES_PRESCALER_EN.
module caravel_user_counter
    import caravel_user_counter_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int COUNT_W  = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb,
    caravel_user_counter_if.slave wbs
);

    logic               en;
    logic               req;
    logic               tick;
    logic               wrap;
    logic [COUNT_W-1:0] cnt;
    logic [15:0]        prescale;
    logic [31:0]        rdata;

    assign en  = io_in[EN_PIN];
    assign req = wbs.wbs_stb_i && wbs.wbs_cyc_i && !wbs.wbs_ack_o;

`ifdef HONZALES_PRESCALER_EN
    logic wr_pre;

    assign wr_pre = req && wbs.wbs_we_i
                 && (decode(wbs.wbs_adr_i) == SEL_PRE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            prescale <= 16'(PRESCALE);
        else if (wr_pre)
            prescale <= (wbs.wbs_dat_i[15:0] == 16'd0) ? 16'd1
                                                       : wbs.wbs_dat_i[15:0];
    end

    // a prescale write restarts the step period from zero
    tick_gen u_tick (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (!en || wr_pre),
        .period (prescale),
        .tick   (tick)
    );

    logic unused_ok;
    assign unused_ok = ^{io_in[37:33], io_in[31:0], wbs.wbs_dat_i[31:16]};
`else
    assign prescale = 16'd1;
    assign tick     = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{io_in[37:33], io_in[31:0],
                         wbs.wbs_dat_i, wbs.wbs_we_i};
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !en) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= tick && (cnt == '1);
            if (tick)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        io_out = '0;
        io_out[CNT_LSB +: COUNT_W] = cnt;
        io_out[WRAP_PIN] = wrap;
        io_oeb = OEB_VAL;
    end

    always_comb begin
        rdata = '0;
        unique case (decode(wbs.wbs_adr_i))
            SEL_CNT:  rdata = 32'(cnt);
            SEL_PRE:  rdata = 32'(prescale);
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
        end else begin
            wbs.wbs_ack_o <= req;
            wbs.wbs_dat_o <= req ? rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_caravel_user_counter.sv
// Randomised bench for caravel_user_counter against a time-based count model.
// Works with or without HONZALES_PRESCALER_EN defined.
module tb_caravel_user_counter;
    import caravel_user_counter_pkg::*;

    localparam int P = 16;
`ifdef HONZALES_PRESCALER_EN
    localparam bit PS_EN = 1'b1;
    localparam int P_EXP = P;
`else
    localparam bit PS_EN = 1'b0;
    localparam int P_EXP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    caravel_user_counter_if wbs();

    caravel_user_counter #(.PRESCALE(P), .COUNT_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .wbs      (wbs)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: count = base + (enabled cycles since last restart) / period
    int          m_base;
    int          m_since;
    int          m_per;
    bit          m_ack;
    bit          m_wrap;
    logic [31:0] m_dat;

    function automatic int m_cnt();
        return (m_base + m_since / m_per) % 256;
    endfunction

    task automatic step();
        int          old;
        bit          rq;
        bit          wr;
        logic [31:0] rd;
        @(posedge clk);
        if (rst) begin
            m_base = 0; m_since = 0; m_per = PS_EN ? P : 1;
            m_ack = 0; m_dat = 0; m_wrap = 0;
        end else begin
            old = m_cnt();
            rq = wbs.wbs_stb_i && wbs.wbs_cyc_i && !m_ack;
            rd = 0;
            if (rq && wbs.wbs_adr_i == CNT_ADDR)
                rd = 32'(old);
            else if (rq && wbs.wbs_adr_i == PRESCALE_ADDR)
                rd = PS_EN ? 32'(m_per) : 32'd1;
            wr = PS_EN && rq && wbs.wbs_we_i
              && wbs.wbs_adr_i == PRESCALE_ADDR;
            if (wr) begin
                m_base = old; m_since = 0;
                m_per = (wbs.wbs_dat_i[15:0] == 0) ? 1
                                                   : int'(wbs.wbs_dat_i[15:0]);
            end
            if (!io_in[EN_PIN]) begin
                m_base = 0; m_since = 0; m_wrap = 0;
            end else if (wr) begin
                m_wrap = 0;
            end else begin
                m_since++;
                m_wrap = (old == 255) && (m_cnt() == 0);
            end
            m_ack = rq;
            m_dat = rd;
        end
        #1;
        check("io_out", 64'(io_out), 64'({29'b0, m_wrap, 8'(m_cnt())}));
        check("io_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FE00));
        check("ack", 64'(wbs.wbs_ack_o), 64'(m_ack));
        check("dat_o", 64'(wbs.wbs_dat_o), 64'(m_dat));
    endtask

    task automatic wb_xfer(input bit we, input logic [31:0] adr,
                           input logic [31:0] dat, output logic [31:0] rdat);
        bit got;
        got = 0;
        rdat = 0;
        wbs.wbs_stb_i = 1; wbs.wbs_cyc_i = 1; wbs.wbs_we_i = we;
        wbs.wbs_adr_i = adr; wbs.wbs_dat_i = dat;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            if (wbs.wbs_ack_o) begin
                got = 1;
                rdat = wbs.wbs_dat_o;
            end
        end
        check("wb_ack_seen", 64'(got), 64'd1);
        wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0; wbs.wbs_we_i = 0;
    endtask

    logic [31:0] r1;
    logic [31:0] r2;
    int          wraps;
    bit          hit;

    initial begin
        rst = 1;
        io_in = '0;
        io_in[EN_PIN] = 1;
        m_per = P;
        wbs.wbs_stb_i = 1; wbs.wbs_cyc_i = 1; wbs.wbs_we_i = 1;
        wbs.wbs_adr_i = PRESCALE_ADDR; wbs.wbs_dat_i = 32'd3;

        // reset dominates enable and a pending write
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_cnt", 64'(io_out[7:0]), 64'd0);
        end
        wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0; wbs.wbs_we_i = 0;
        rst = 0;

        // free run from reset release: steps and one wrap at 256*P
        wraps = 0;
        for (int n = 1; n <= 4100; n++) begin
            step();
            if (io_out[WRAP_PIN]) wraps++;
            if (n % P_EXP == 0 && n / P_EXP <= 10)
                check("step_k", 64'(io_out[7:0]), 64'(n / P_EXP));
            if (n == 255 * P_EXP)
                check("reach_ff", 64'(io_out[7:0]), 64'hFF);
            if (n == 256 * P_EXP) begin
                check("wrap_00", 64'(io_out[7:0]), 64'h00);
                check("wrap_pulse", 64'(io_out[WRAP_PIN]), 64'd1);
            end
        end
        check("wrap_count", 64'(wraps), 64'(4100 / (256 * P_EXP)));

        // enable dropped at 0x05
        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            if (m_cnt() == 5) hit = 1;
            else step();
        end
        check("reach_05", 64'(hit), 64'd1);
        io_in[EN_PIN] = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("dis_zero", 64'(io_out[7:0]), 64'd0);
        end
        io_in[EN_PIN] = 1;
        for (int i = 0; i < P_EXP; i++) step();
        check("reen_01", 64'(io_out[7:0]), 64'd1);

        // prescale 4: reads 8 cycles apart differ by 8/period
        wb_xfer(1, PRESCALE_ADDR, 32'd4, r1);
        wb_xfer(0, CNT_ADDR, 32'd0, r1);
        for (int i = 0; i < 7; i++) step();
        wb_xfer(0, CNT_ADDR, 32'd0, r2);
        check("rd_diff", 64'((r2 - r1) & 32'hFF), PS_EN ? 64'd2 : 64'd8);

        // random traffic, enable toggling and ignored pad inputs
        for (int t = 0; t < 150; t++) begin
            int idle;
            int sel;
            logic [31:0] a;
            idle = $urandom_range(0, 20);
            for (int i = 0; i < idle; i++) begin
                io_in[31:0] = $urandom;
                io_in[37:33] = 5'($urandom);
                if ($urandom_range(0, 40) == 0)
                    io_in[EN_PIN] = ~io_in[EN_PIN];
                step();
            end
            sel = $urandom_range(0, 2);
            a = (sel == 0) ? CNT_ADDR : (sel == 1) ? PRESCALE_ADDR
                                                   : 32'h3000_0008;
            wb_xfer(1'($urandom), a, 32'($urandom_range(0, 6)), r1);
        end

        // reset mid-count at 0xFE: no wrap, prescale back to default
        io_in[EN_PIN] = 1;
        wb_xfer(1, PRESCALE_ADDR, 32'd1, r1);
        hit = 0;
        for (int i = 0; i < 600 && !hit; i++) begin
            if (m_cnt() == 254) hit = 1;
            else step();
        end
        check("reach_fe", 64'(hit), 64'd1);
        rst = 1;
        step();
        check("rst_mid_cnt", 64'(io_out[7:0]), 64'd0);
        check("rst_mid_wrap", 64'(io_out[WRAP_PIN]), 64'd0);
        rst = 0;
        wb_xfer(0, PRESCALE_ADDR, 32'd0, r1);
        check("pre_after_rst", 64'(r1), PS_EN ? 64'd16 : 64'd1);
        step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
